// File: rtl/iis_transmit.sv
// iis_transmit: FIFO-fed I2S transmitter, 32 SCK per slot, 16-bit words sent MSB first.
// The FIFO read for a slot is issued at bit 29 of the previous slot (or in PREFETCH for the first).
module iis_transmit #(
  parameter int unsigned data_depth = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_en,
  input  logic [15:0] fifo_rdata,
  input  logic        fifo_empty,
  output logic        rd_clk,
  output logic        fifo_rden,
  output logic        WS,
  output logic        SD,
  output logic [15:0] L_DATA,
  output logic [15:0] R_DATA,
  output logic [31:0] tx_num,
  output logic        tx_finish,
  output logic        underrun
);
  typedef enum logic [1:0] {IDLE, PREFETCH, CAPTURE, RUN} state_t;
  state_t state, state_n;
  logic [4:0] bit_cnt;
  logic [15:0] shift, hold, load_word;
  logic hold_ok, miss, rd_req, cap, load, load_ok, last, left_n;
  assign rd_clk = clk;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = !tx_en ? IDLE : state == IDLE ? PREFETCH : state == PREFETCH ? CAPTURE : RUN;
    rd_req = tx_en && (state == IDLE || (state == RUN && bit_cnt == 5'd28));
    cap = tx_en && (state == CAPTURE || (state == RUN && bit_cnt == 5'd30));
    load = tx_en && (state == CAPTURE || (state == RUN && bit_cnt == 5'd31));
    load_word = state == CAPTURE ? (miss ? 16'h0 : fifo_rdata) : hold;
    load_ok = state == CAPTURE ? !miss : hold_ok;
    last = tx_num + 32'd1 == data_depth;
    left_n = state == CAPTURE || !WS;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      WS <= 1'b0;
      SD <= 1'b0;
      fifo_rden <= 1'b0;
      tx_finish <= 1'b0;
      underrun <= 1'b0;
      L_DATA <= '0;
      R_DATA <= '0;
      tx_num <= '0;
      shift <= '0;
      hold <= '0;
      hold_ok <= 1'b0;
      miss <= 1'b0;
    end else if (!tx_en) begin
      bit_cnt <= '0;
      WS <= 1'b0;
      SD <= 1'b0;
      fifo_rden <= 1'b0;
      tx_finish <= 1'b0;
      underrun <= 1'b0;
      tx_num <= '0;
    end else begin
      bit_cnt <= state == RUN ? bit_cnt + 5'd1 : 5'd0;
      fifo_rden <= rd_req && !fifo_empty;
      underrun <= underrun || (rd_req && fifo_empty);
      if (rd_req) miss <= fifo_empty;
      if (cap) begin
        hold <= miss ? 16'h0 : fifo_rdata;
        hold_ok <= !miss;
      end
      // bit_cnt n-1 selects the bit shown during bit_cnt n
      SD <= state == RUN && bit_cnt < 5'd16 && shift[~bit_cnt[3:0]];
      tx_finish <= load && load_ok && last;
      if (load) begin
        shift <= load_word;
        WS <= left_n;
        if (left_n) L_DATA <= load_word;
        else R_DATA <= load_word;
        if (load_ok) tx_num <= last ? 32'd0 : tx_num + 32'd1;
      end
    end
  end
endmodule

// File: doc/iis_transmit.md
IIS_TRANSMIT -- requirements
Module: iis_transmit

Interface
REQ-001 Parameter data_depth, default 1024, is the number of FIFO words per transfer block; legal range is 1..2^32-1.
REQ-002 clk  in  1  bit clock (SCK domain); all logic on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 tx_en  in  1  transmit enable; low forces IDLE.
REQ-005 fifo_rdata  in  16  FIFO read data, valid the cycle after fifo_rden.
REQ-006 fifo_empty  in  1  FIFO empty flag.
REQ-007 rd_clk  out  1  FIFO read clock, driven directly from clk.
REQ-008 fifo_rden  out  1  registered FIFO read strobe, one-cycle pulses.
REQ-009 WS  out  1  word select, registered; 1 = left slot, 0 = right slot.
REQ-010 SD  out  1  serial data, registered, MSB first.
REQ-011 L_DATA / R_DATA  out  16 each  last word loaded for left / right slot.
REQ-012 tx_num  out  32  count of FIFO words loaded in the current block.
REQ-013 tx_finish  out  1  registered one-cycle pulse at block completion.
REQ-014 underrun  out  1  sticky flag: a slot was loaded while the FIFO was empty.

Function
REQ-015 FSM states: IDLE, PREFETCH, CAPTURE, RUN; transitions occur only while tx_en=1, and any cycle with tx_en=0 moves to IDLE at the next edge.
REQ-016 IDLE->PREFETCH when tx_en=1; PREFETCH->CAPTURE; CAPTURE->RUN with bit_cnt=0, chan=LEFT.
REQ-017 PREFETCH: fifo_rden=1 if fifo_empty=0, else fifo_rden=0 and underrun set.
REQ-018 CAPTURE: fifo_rdata (or 0 on underrun) latched into the hold register.
REQ-019 RUN: 5-bit bit_cnt counts 0..31 and wraps; chan toggles on each wrap; each half-frame is 32 clk.
REQ-020 At each entry to bit_cnt=0, the hold word loads into the 16-bit shift register and into L_DATA (chan LEFT) or R_DATA (chan RIGHT).
REQ-021 WS=1 throughout a LEFT half-frame and 0 throughout a RIGHT half-frame, changing on the cycle bit_cnt becomes 0.
REQ-022 SD = shift register bit 15-(n-1) during bit_cnt=n for n=1..16 (MSB at n=1, LSB at n=16); SD=0 at bit_cnt=0 and 17..31.
REQ-023 Prefetch during RUN: at bit_cnt=29, fifo_rden=1 if fifo_empty=0; at bit_cnt=30, fifo_rdata is captured into hold.
REQ-024 If fifo_empty=1 at bit_cnt=29: no read, hold=0, underrun set, and the slot transmits zeros.
REQ-025 tx_num increments by 1 on each shift-register load sourced from the FIFO; zero-filled loads do not count.
REQ-026 When an increment would make tx_num equal data_depth: tx_num becomes 0 and tx_finish=1 for exactly that cycle; streaming continues without gap.
REQ-027 tx_en=0 at any point: next edge gives IDLE, WS=0, SD=0, fifo_rden=0, bit_cnt=0, tx_num=0, underrun=0; the partial slot is abandoned and no FIFO read is issued.
REQ-028 At most one fifo_rden pulse per half-frame in RUN; no reads in IDLE.

Reset
REQ-029 rst=1 at a clock edge: state=IDLE and WS, SD, fifo_rden, tx_finish, underrun, L_DATA, R_DATA, tx_num, bit_cnt, shift and hold registers all 0; rst overrides tx_en.
REQ-030 Reset mid-RUN behaves as REQ-029 on the next edge; the first fifo_rden after release is PREFETCH.

Verification
REQ-031 FIFO holds 0xA5C3 then 0x0F0F, tx_en=1 -> WS rises 2 cycles after the PREFETCH read; SD carries 1010010111000011 on bit_cnt 1..16 with WS=1; the right slot carries 0x0F0F with WS=0; L_DATA=0xA5C3, R_DATA=0x0F0F.
REQ-032 Loop SD/WS into the receive block, 8 random words -> the receiver SDATA sequence equals the FIFO order.
REQ-033 data_depth=4, FIFO never empty -> tx_finish pulses once per 4 loads (every 128 clk), and tx_num cycles 1,2,3,0.
REQ-034 FIFO empty at the second bit_cnt=29 -> no fifo_rden, the right slot is all zeros, underrun=1 stays set, and tx_num does not increment.
REQ-035 tx_en dropped at bit_cnt=8 -> next cycle WS=0, SD=0, tx_num=0, underrun=0; re-enable restarts with PREFETCH.
REQ-036 rst pulsed mid-RUN with tx_en held high -> all outputs 0 the cycle after rst, then PREFETCH resumes the cycle after rst deasserts.
